// File: rtl/fetch_pkg.sv
// Shared fetch definitions: widths, NOP encoding, reset pc,
// FSM state enum and the {pc,instr} FIFO entry.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_ent_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc,instr} prefetch FIFO with synchronous flush.
// Flush wins over a same-cycle push or pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_ent_t    push_ent,
  input  logic          pop,
  output fetch_ent_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  fetch_ent_t mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= nxt(wr);
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= push_ent;
  end

  assign head  = mem[rd];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue with redirect/drain handling.
// Optional FETCH_MISALIGN_CHECK_EN flags misaligned redirect targets.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_e state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nxt;
  logic [CW-1:0]   occ;
  logic [CW:0]     inflight;
  logic            req_hs;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full_unused;
  fetch_ent_t      head;

  assign target   = {redirect_pc[31:2], 2'b00};
  assign inflight = {1'b0, occ} + {1'b0, outstanding};

  assign imem_req_valid = (state == RUN) && !redirect_valid
                          && (inflight < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid & imem_req_ready;

  assign push = (state == RUN) && imem_rsp_valid && !redirect_valid;
  assign pop  = out_valid & out_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .flush   (redirect_valid),
    .push    (push),
    .push_ent('{pc: rsp_pc, instr: imem_rsp_data}),
    .pop     (pop),
    .head    (head),
    .count   (occ),
    .full    (full_unused),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign out_instr = out_valid ? head.instr : INSTR_NOP;
  assign out_pc    = out_valid ? head.pc : last_pc;

  // In DRAIN every in-flight response is stale, so outstanding == drop_cnt
  always_comb begin
    drop_nxt  = drop_cnt;
    state_nxt = state;
    if (redirect_valid)
      drop_nxt = outstanding - CW'(imem_rsp_valid);
    else if (state == DRAIN && imem_rsp_valid)
      drop_nxt = drop_cnt - CW'(1);
    state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      drop_cnt    <= drop_nxt;
      outstanding <= outstanding + CW'(req_hs) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= target;
        rsp_pc   <= target;
      end else begin
        if (req_hs) fetch_pc <= fetch_pc + 32'd4;
        if (push) rsp_pc <= rsp_pc + 32'd4;
      end
      if (out_valid) last_pc <= head.pc;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else mis_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
  assign misalign_err = mis_q;
`else
  logic unused_lo;
  assign unused_lo    = ^redirect_pc[1:0];
  assign misalign_err = 1'b0;
`endif
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, prefetch slots; legal range 2..8.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 redirect_valid  in  1  taken branch/jump/jalr from execute.
REQ-006 redirect_pc  in  32  new fetch target.
REQ-007 imem_req_valid  out  1  instruction-memory read request.
REQ-008 imem_req_ready  in  1  memory accepts request.
REQ-009 imem_req_addr  out  32  word-aligned fetch address.
REQ-010 imem_rsp_valid  in  1  read data returned, in request order, at least 1 cycle after acceptance.
REQ-011 imem_rsp_data  in  32  instruction word.
REQ-012 out_valid  out  1  instruction available to decode and imm_extend.
REQ-013 out_ready  in  1  decode consumes instruction.
REQ-014 out_instr  out  32  instruction; out_instr[31:7] feeds the immediate extender.
REQ-015 out_pc  out  32  address of out_instr.
REQ-016 misalign_err  out  1  one-cycle pulse on a misaligned redirect.

Function
REQ-017 fetch_pc register drives imm_req_addr; it advances by 4 (mod 2^32, wraps silently) on each request handshake (imem_req_valid & imem_req_ready).
REQ-018 imem_req_valid is asserted when state is RUN and occupancy + outstanding < DEPTH; it is deasserted otherwise.
REQ-019 outstanding increments on request handshake, decrements on imem_rsp_valid; a simultaneous increment and decrement leaves it unchanged.
REQ-020 In RUN, each response is pushed into the FIFO together with its pc; out_valid rises the cycle after the push (no combinational bypass).
REQ-021 out_valid & out_ready pops the FIFO head; a push and a pop in the same cycle keep occupancy constant.
REQ-022 When out_valid=0, out_instr is 32'h0000_0013 (NOP) and out_pc holds its last value.
REQ-023 On redirect_valid: the FIFO is flushed, fetch_pc <= {redirect_pc[31:2],2'b00}, drop_cnt <= outstanding (net of same-cycle response), and no request is issued that cycle.
REQ-024 FSM states: RUN, DRAIN. RUN->DRAIN on redirect with drop_cnt>0 after update; RUN stays RUN on redirect with drop_cnt=0; DRAIN->RUN when drop_cnt reaches 0.
REQ-025 In DRAIN, responses are discarded, drop_cnt decrements on each, and no requests are issued.
REQ-026 A redirect in DRAIN reloads fetch_pc and keeps draining the remaining drop_cnt.
REQ-027 Redirect has priority over a same-cycle pop and push; the popped instruction is still consumed by decode, and the pushed response is dropped.

Reset
REQ-028 During reset: fetch_pc=RESET_PC, state=RUN, occupancy=0, outstanding=0, drop_cnt=0, out_valid=0, misalign_err=0, out_pc=RESET_PC.
REQ-029 A reset asserted mid-transaction abandons all outstanding responses; the memory is reset by the same signal.
REQ-030 The first request (addr RESET_PC) is issued in the first cycle after reset deasserts.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN: when defined, a redirect with redirect_pc[1:0]!=0 produces a registered misalign_err pulse the following cycle, and the redirect still takes effect with the low bits cleared.
REQ-032 When FETCH_MISALIGN_CHECK_EN is undefined, misalign_err is tied to 0 and the low bits are cleared silently.

Structure
REQ-033 Shared package fetch_pkg holds XLEN=32, INSTR_NOP=32'h0000_0013, the default RESET_PC and the fetch state enum {RUN, DRAIN}.
REQ-034 Sub-module fetch_fifo holds a DEPTH-entry {pc,instr} FIFO with synchronous flush, push, pop, full and empty; fetch_queue instantiates it once.

Verification
REQ-035 Reset release, memory 1-cycle latency, out_ready=1: requests go to 0x0,0x4,0x8 on consecutive cycles, and out_instr/out_pc stream in order with out_valid rising 2 cycles after the first request.
REQ-036 out_ready=0 with DEPTH=2: after 2 responses, imem_req_valid=0 and the FIFO holds exactly 0x0 and 0x4; raising out_ready resumes requests at 0x8.
REQ-037 Redirect to 0x100 with 2 outstanding: state enters DRAIN, both stale responses are dropped, the next request address is 0x100, and out_pc=0x100 is the first valid output.
REQ-038 Redirect with a same-cycle response and pop: the response is dropped, the FIFO is empty the next cycle, and no stale pc appears on out_pc.
REQ-039 With FETCH_MISALIGN_CHECK_EN defined, redirect_pc=0x102 gives a misalign_err one-cycle pulse and the next request address 0x100; without the macro, misalign_err stays 0.
REQ-040 With fetch_pc=0xFFFF_FFFC, the request handshake wraps the next address to 0x0000_0000.
